// File: rtl/ic_miss_queue_pkg.sv
// Shared definitions for the instruction-cache miss queue: command codes,
// default line geometry, issue FSM states and the line-address helper.
package ic_miss_queue_pkg;

  localparam logic [3:0] CMD_INST_FETCH = 4'd2;
  localparam logic [3:0] CMD_INVALIDATE = 4'd3;
  localparam logic [3:0] CMD_PRINT      = 4'd4;
  localparam logic [3:0] CMD_RESET      = 4'd8;

  localparam int LINE_OFF_DEFAULT = 6;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_REQ       = 2'd1,
    S_WAIT_FILL = 2'd2
  } miss_state_e;

  // Clear the byte-within-line bits so every address in a line compares equal.
  function automatic logic [31:0] line_addr(input logic [31:0] addr, input int off);
    logic [31:0] mask;
    mask = (32'd1 << off) - 32'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/ic_miss_fifo.sv
// Miss-queue storage: circular buffer with read/write pointers and an
// occupancy count, plus a parallel compare of a line against every live entry.
module ic_miss_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          trim_i,
  input  logic          keep_head_i,
  input  logic          pop_i,
  input  logic          push_i,
  input  logic [31:0]   push_line_i,
  input  logic [31:0]   cmp_line_i,
  output logic [31:0]   head_o,
  output logic [31:0]   head_next_o,
  output logic [CW-1:0] count_o,
  output logic [CW-1:0] count_next_o,
  output logic          match_o,
  output logic          can_push_o
);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;

  // State after a flush or trim but before this cycle's pop and push.
  logic [AW-1:0] rd_a, wr_a;
  logic [CW-1:0] cnt_a;
  logic          pop_ok;
  logic [AW-1:0] off;

  always_comb begin
    rd_a  = rd_q;
    wr_a  = wr_q;
    cnt_a = count_q;
    if (flush_i) begin
      rd_a  = '0;
      wr_a  = '0;
      cnt_a = '0;
    end else if (trim_i) begin
      cnt_a = (keep_head_i && count_q != '0) ? CW'(1) : '0;
      wr_a  = rd_q + cnt_a[AW-1:0];
    end

    pop_ok     = pop_i && (cnt_a != '0);
    can_push_o = (cnt_a != CW'(DEPTH)) || pop_ok;

    rd_d = pop_ok ? rd_a + AW'(1) : rd_a;
    wr_d = push_i ? wr_a + AW'(1) : wr_a;

    count_d = cnt_a;
    if (pop_ok && !push_i)      count_d = cnt_a - CW'(1);
    else if (push_i && !pop_ok) count_d = cnt_a + CW'(1);

    head_next_o = (push_i && wr_a == rd_d) ? push_line_i : mem_q[rd_d];
  end

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    match_o = 1'b0;
    off     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd_a;
      if (({1'b0, off} < cnt_a) && (mem_q[i] == cmp_line_i)) match_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      if (push_i) mem_q[wr_a] <= push_line_i;
    end
  end

  assign head_o       = mem_q[rd_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/ic_miss_queue.sv
// Instruction-cache miss queue: coalesces misses by line, issues them one at
// a time to next-level memory. Define IC_MISS_STATS_EN for miss/coalesce/drop counters.
//
// Handshake: mem_req/mem_addr are held until mem_ack is seen in REQ; the line is
// then outstanding until a mem_done in WAIT_FILL, which pops it and pulses fill_valid.
module ic_miss_queue
  import ic_miss_queue_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int LINE_OFF = LINE_OFF_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  n,
  input  logic [31:0] add_out,
  input  logic        miss,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_done,
  output logic        fill_valid,
  output logic [31:0] fill_addr,
  output logic        full,
  output logic        empty,
  output logic        drop
`ifdef IC_MISS_STATS_EN
  ,
  output logic [31:0] miss_cnt,
  output logic [31:0] coal_cnt,
  output logic [31:0] drop_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  miss_state_e state_q, state_d;

  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        fill_valid_q, fill_valid_d;
  logic [31:0] fill_addr_q, fill_addr_d;
  logic        drop_q, drop_d;

  logic          cmd_reset, cmd_inval;
  logic [31:0]   line;
  logic          miss_live, match, can_push, push, pop_fire, keep_head;
  logic [31:0]   head, head_next;
  logic [CW-1:0] count, count_next;

  assign cmd_reset = (n == CMD_RESET);
  assign cmd_inval = (n == CMD_INVALIDATE);
  assign line      = line_addr(add_out, LINE_OFF);
  assign miss_live = miss && !cmd_reset;
  assign keep_head = (state_q == S_REQ) || (state_q == S_WAIT_FILL);
  assign pop_fire  = (state_q == S_WAIT_FILL) && mem_done && !cmd_reset;
  assign push      = miss_live && !match && can_push;

  ic_miss_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (cmd_reset),
    .trim_i       (cmd_inval),
    .keep_head_i  (keep_head),
    .pop_i        (pop_fire),
    .push_i       (push),
    .push_line_i  (line),
    .cmp_line_i   (line),
    .head_o       (head),
    .head_next_o  (head_next),
    .count_o      (count),
    .count_next_o (count_next),
    .match_o      (match),
    .can_push_o   (can_push)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      fill_valid_q <= 1'b0;
      fill_addr_q  <= '0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      fill_valid_q <= fill_valid_d;
      fill_addr_q  <= fill_addr_d;
      drop_q       <= drop_d;
    end
  end

  // Decisions look at the post-edge occupancy so a miss into an idle queue
  // raises mem_req in the very next cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (count_next != '0) state_d = S_REQ;
      S_REQ:       if (mem_ack) state_d = S_WAIT_FILL;
      S_WAIT_FILL: if (mem_done) state_d = (count_next != '0) ? S_REQ : S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    if (cmd_reset) state_d = S_IDLE;
  end

  always_comb begin
    mem_req_d    = (state_d == S_REQ);
    mem_addr_d   = mem_addr_q;
    if (state_d == S_REQ && state_q != S_REQ) mem_addr_d = head_next;
    fill_valid_d = pop_fire;
    fill_addr_d  = pop_fire ? head : fill_addr_q;
    drop_d       = miss_live && !match && !can_push;
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign fill_valid = fill_valid_q;
  assign fill_addr  = fill_addr_q;
  assign drop       = drop_q;
  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);

`ifdef IC_MISS_STATS_EN
  logic [31:0] miss_cnt_q, coal_cnt_q, drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_cnt_q <= '0;
      coal_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else if (cmd_reset) begin
      miss_cnt_q <= '0;
      coal_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (miss && miss_cnt_q != '1)          miss_cnt_q <= miss_cnt_q + 32'd1;
      if (miss && match && coal_cnt_q != '1) coal_cnt_q <= coal_cnt_q + 32'd1;
      if (drop_d && drop_cnt_q != '1)        drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign miss_cnt = miss_cnt_q;
  assign coal_cnt = coal_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_ic_miss_queue.sv
// Directed bench for ic_miss_queue (DEPTH=4, LINE_OFF=6); expected values are
// hand-computed line addresses. Stats checks compile in with IC_MISS_STATS_EN.
module tb_ic_miss_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  n = 4'd2;
  logic [31:0] add_out = '0;
  logic        miss = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic        mem_done = 1'b0;
  logic        fill_valid;
  logic [31:0] fill_addr;
  logic        full, empty, drop;
`ifdef IC_MISS_STATS_EN
  logic [31:0] miss_cnt, coal_cnt, drop_cnt;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int drop_pulses = 0;

  ic_miss_queue dut (
    .clk(clk), .rst_n(rst_n), .n(n), .add_out(add_out), .miss(miss),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_done(mem_done),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .full(full), .empty(empty), .drop(drop)
`ifdef IC_MISS_STATS_EN
    , .miss_cnt(miss_cnt), .coal_cnt(coal_cnt), .drop_cnt(drop_cnt)
`endif
  );

  // Clock and reset-independent monitors
  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && drop) drop_pulses++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change 1ns after a rising edge, outputs read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_miss(input logic [31:0] a);
    miss = 1'b1;
    add_out = a;
    tick();
    miss = 1'b0;
  endtask

  task automatic serve(input string tag, input logic [31:0] exp_line);
    int k = 0;
    while (!mem_req && k < 20) begin
      tick();
      k++;
    end
    check_eq({tag, "_req"}, {31'd0, mem_req}, 32'd1);
    check_eq({tag, "_addr"}, mem_addr, exp_line);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    check_eq({tag, "_fv"}, {31'd0, fill_valid}, 32'd1);
    check_eq({tag, "_faddr"}, fill_addr, exp_line);
  endtask

  int d0;

  initial begin
    // Reset state
    #2;
    check_eq("rst_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_addr", mem_addr, 32'd0);
    check_eq("rst_fv", {31'd0, fill_valid}, 32'd0);
    check_eq("rst_faddr", fill_addr, 32'd0);
    check_eq("rst_flags", {29'd0, full, empty, drop}, 32'b010);
    #20 rst_n = 1'b1;
    tick();

    // Single miss, minimum latency
    do_miss(32'hFACEB00B);
    check_eq("single_req", {31'd0, mem_req}, 32'd1);
    check_eq("single_addr", mem_addr, 32'hFACEB000);
    check_eq("single_empty", {31'd0, empty}, 32'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check_eq("single_req_drop", {31'd0, mem_req}, 32'd0);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    check_eq("single_fv", {31'd0, fill_valid}, 32'd1);
    check_eq("single_faddr", fill_addr, 32'hFACEB000);
    check_eq("single_empty_after", {31'd0, empty}, 32'd1);
    tick();
    check_eq("single_fv_pulse", {31'd0, fill_valid}, 32'd0);

    // Coalesce two misses to the same line
    do_miss(32'hFACEB00B);
    do_miss(32'hFACEB03C);
    serve("coal", 32'hFACEB000);
    check_eq("coal_empty", {31'd0, empty}, 32'd1);
    tick();
    check_eq("coal_one_req", {31'd0, mem_req}, 32'd0);

    // Order, full and drop
    d0 = drop_pulses;
    do_miss(32'hFACEB00B);
    do_miss(32'hDEADBEEF);
    do_miss(32'h0BEEFA55);
    do_miss(32'h00001000);
    check_eq("ord_full", {31'd0, full}, 32'd1);
    do_miss(32'h00002000);
    check_eq("ord_drop", {31'd0, drop}, 32'd1);
    check_eq("ord_full2", {31'd0, full}, 32'd1);
    serve("ord0", 32'hFACEB000);
    check_eq("ord_drop_pulses", drop_pulses - d0, 32'd1);
    serve("ord1", 32'hDEADBEC0);
    serve("ord2", 32'h0BEEFA40);
    serve("ord3", 32'h00001000);
    check_eq("ord_empty", {31'd0, empty}, 32'd1);
    tick();

    // Full with simultaneous pop and new miss
    d0 = drop_pulses;
    do_miss(32'h00001000);
    do_miss(32'h00002000);
    do_miss(32'h00003000);
    do_miss(32'h00004000);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    mem_done = 1'b1;
    miss = 1'b1;
    add_out = 32'h00005004;
    tick();
    mem_done = 1'b0;
    miss = 1'b0;
    check_eq("pp_fv", {31'd0, fill_valid}, 32'd1);
    check_eq("pp_faddr", fill_addr, 32'h00001000);
    check_eq("pp_full", {31'd0, full}, 32'd1);
    check_eq("pp_nodrop", {31'd0, drop}, 32'd0);
    serve("pp1", 32'h00002000);
    serve("pp2", 32'h00003000);
    serve("pp3", 32'h00004000);
    serve("pp4", 32'h00005000);
    check_eq("pp_drop_pulses", drop_pulses - d0, 32'd0);
    check_eq("pp_empty", {31'd0, empty}, 32'd1);
    tick();

    // INVALIDATE in WAIT_FILL keeps only the in-flight head
    do_miss(32'h00001000);
    do_miss(32'h00002000);
    do_miss(32'h00003000);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    n = 4'd3;
    tick();
    n = 4'd2;
    check_eq("inv_empty", {31'd0, empty}, 32'd0);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    check_eq("inv_fv", {31'd0, fill_valid}, 32'd1);
    check_eq("inv_faddr", fill_addr, 32'h00001000);
    check_eq("inv_empty_after", {31'd0, empty}, 32'd1);
    tick();
    check_eq("inv_no_req", {31'd0, mem_req}, 32'd0);

    // RESET command in WAIT_FILL, then a late mem_done
    do_miss(32'h00006000);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    n = 4'd8;
    miss = 1'b1;
    add_out = 32'h00009000;
    tick();
    n = 4'd2;
    miss = 1'b0;
    check_eq("cr_req", {31'd0, mem_req}, 32'd0);
    check_eq("cr_empty", {31'd0, empty}, 32'd1);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    check_eq("cr_no_fv", {31'd0, fill_valid}, 32'd0);
    tick();
    check_eq("cr_no_fv2", {31'd0, fill_valid}, 32'd0);
    check_eq("cr_still_idle", {31'd0, mem_req}, 32'd0);

    // Asynchronous reset during REQ
    do_miss(32'h00007000);
    check_eq("ar_req_before", {31'd0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar_req", {31'd0, mem_req}, 32'd0);
    check_eq("ar_empty", {31'd0, empty}, 32'd1);
    rst_n = 1'b1;
    tick();
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    check_eq("ar_no_fv", {31'd0, fill_valid}, 32'd0);

`ifdef IC_MISS_STATS_EN
    // Counters restart from the reset above
    do_miss(32'h00001000);
    do_miss(32'h00001010);
    do_miss(32'h00002000);
    check_eq("st_miss", miss_cnt, 32'd3);
    check_eq("st_coal", coal_cnt, 32'd1);
    check_eq("st_drop", drop_cnt, 32'd0);
    serve("st0", 32'h00001000);
    serve("st1", 32'h00002000);
    n = 4'd8;
    tick();
    n = 4'd2;
    check_eq("st_clear", miss_cnt, 32'd0);
`endif

    // Report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
